// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef logic [1:0] grant_t;

   localparam grant_t GNT_NONE   = 2'd0;
   localparam grant_t GNT_ICACHE = 2'd1;
   localparam grant_t GNT_DCACHE = 2'd2;
   localparam grant_t GNT_PERIPH = 2'd3;

   // Width of the watchdog counter; never below one bit so the counter
   // still exists when the watchdog is disabled (timeout_cycles == 0).
   function automatic int timeout_cnt_width(input int timeout_cycles);
      return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_pick3.sv
// Three-way round-robin selector: the search starts just after the
// requester that owned the bus last.
module rr_pick3
   import bus_arb_pkg::*;
(
   input  logic [2:0] req_i,    // bit 0 icache, bit 1 dcache, bit 2 periph
   input  grant_t     last_i,
   output grant_t     winner_o
);

   // Rotated fixed-priority search selected by the previous owner.
   always_comb begin
      // NOTE: default assigned first so every path drives winner_o and no latch is inferred.
      winner_o = GNT_NONE;
      case (last_i)
         GNT_ICACHE: begin
            if      (req_i[1]) winner_o = GNT_DCACHE;
            else if (req_i[2]) winner_o = GNT_PERIPH;
            else if (req_i[0]) winner_o = GNT_ICACHE;
         end
         GNT_DCACHE: begin
            if      (req_i[2]) winner_o = GNT_PERIPH;
            else if (req_i[0]) winner_o = GNT_ICACHE;
            else if (req_i[1]) winner_o = GNT_DCACHE;
         end
         default: begin
            if      (req_i[0]) winner_o = GNT_ICACHE;
            else if (req_i[1]) winner_o = GNT_DCACHE;
            else if (req_i[2]) winner_o = GNT_PERIPH;
         end
      endcase
   end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Registered round-robin arbiter sharing one Wishbone-style bus between the
// I-cache, D-cache and uncached peripheral ports, one transaction at a time,
// with a watchdog that aborts a transaction the bus never acknowledges.
module memory_bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  icache_req_i,
   input  logic [ADDR_WIDTH-1:0] icache_addr_i,
   output logic                  icache_rsp_o,
   input  logic                  dcache_req_i,
   input  logic                  dcache_we_i,
   input  logic [ADDR_WIDTH-1:0] dcache_addr_i,
   input  logic [DATA_WIDTH-1:0] dcache_wdata_i,
   output logic                  dcache_rsp_o,
   input  logic                  periph_req_i,
   input  logic                  periph_we_i,
   input  logic [ADDR_WIDTH-1:0] periph_addr_i,
   input  logic [DATA_WIDTH-1:0] periph_wdata_i,
   output logic                  periph_rsp_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o,
   output logic                  cyc_o,
   output logic                  stb_o,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  ack_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [1:0]            grant_o
);

   localparam int                CNT_W  = timeout_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t            state_q, state_d;
   grant_t                grant_q, grant_d;
   grant_t                last_q,  last_d;
   logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic                  we_q,    we_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q,   err_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;

   logic [2:0] req;
   grant_t     winner;
   logic       timeout_hit;

   assign req         = {periph_req_i, dcache_req_i, icache_req_i};
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_MAX);

   rr_pick3 u_rr_pick3 (
      .req_i    (req),
      .last_i   (last_q),
      .winner_o (winner)
   );

   // Next-state logic: grant in IDLE, wait for ack or timeout in ACTIVE,
   // hand the response back and advance the pointer in RESP.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = winner;
               cnt_d   = '0;
               state_d = ACTIVE;
               case (winner)
                  GNT_ICACHE: begin
                     addr_d = icache_addr_i;
                     data_d = '0;
                     we_d   = 1'b0;
                  end
                  GNT_DCACHE: begin
                     addr_d = dcache_addr_i;
                     data_d = dcache_wdata_i;
                     we_d   = dcache_we_i;
                  end
                  default: begin
                     addr_d = periph_addr_i;
                     data_d = periph_wdata_i;
                     we_d   = periph_we_i;
                  end
               endcase
            end
         end
         ACTIVE: begin
            // ack has priority over a timeout landing in the same cycle.
            if (ack_i) begin
               rdata_d = data_i;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timeout_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else if (TIMEOUT_CYCLES != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            last_d  = grant_q;
            grant_d = GNT_NONE;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and bus registers; reset parks the pointer on periph so icache wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= GNT_NONE;
         last_q  <= GNT_PERIPH;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cyc_o        = (state_q == ACTIVE);
   assign stb_o        = cyc_o;
   assign we_o         = we_q;
   assign addr_o       = addr_q;
   assign data_o       = data_q;
   assign rdata_o      = rdata_q;
   assign err_o        = err_q;
   assign grant_o      = grant_q;
   assign icache_rsp_o = (state_q == RESP) && (grant_q == GNT_ICACHE);
   assign dcache_rsp_o = (state_q == RESP) && (grant_q == GNT_DCACHE);
   assign periph_rsp_o = (state_q == RESP) && (grant_q == GNT_PERIPH);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed scenarios plus a
// randomized run checked against a round-robin reference model.
module tb_memory_bus_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        icache_req_i = 1'b0;
   logic [31:0] icache_addr_i = '0;
   logic        icache_rsp_o;
   logic        dcache_req_i = 1'b0;
   logic        dcache_we_i = 1'b0;
   logic [31:0] dcache_addr_i = '0;
   logic [31:0] dcache_wdata_i = '0;
   logic        dcache_rsp_o;
   logic        periph_req_i = 1'b0;
   logic        periph_we_i = 1'b0;
   logic [31:0] periph_addr_i = '0;
   logic [31:0] periph_wdata_i = '0;
   logic        periph_rsp_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] addr_o;
   logic [31:0] data_o;
   logic        ack_i = 1'b0;
   logic [31:0] data_i = '0;
   logic [1:0]  grant_o;

   int n_pass = 0;
   int n_total = 0;
   int edge_cnt = 0;

   typedef struct {
      logic [1:0]  g;
      logic [31:0] a;
      logic        w;
      logic [31:0] d;
      bit          stable;
      int          len;
      logic [2:0]  rsp;
      logic [31:0] rd;
      logic        er;
   } obs_t;

   memory_bus_arbiter #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .icache_req_i   (icache_req_i),
      .icache_addr_i  (icache_addr_i),
      .icache_rsp_o   (icache_rsp_o),
      .dcache_req_i   (dcache_req_i),
      .dcache_we_i    (dcache_we_i),
      .dcache_addr_i  (dcache_addr_i),
      .dcache_wdata_i (dcache_wdata_i),
      .dcache_rsp_o   (dcache_rsp_o),
      .periph_req_i   (periph_req_i),
      .periph_we_i    (periph_we_i),
      .periph_addr_i  (periph_addr_i),
      .periph_wdata_i (periph_wdata_i),
      .periph_rsp_o   (periph_rsp_o),
      .rdata_o        (rdata_o),
      .err_o          (err_o),
      .cyc_o          (cyc_o),
      .stb_o          (stb_o),
      .we_o           (we_o),
      .addr_o         (addr_o),
      .data_o         (data_o),
      .ack_i          (ack_i),
      .data_i         (data_i),
      .grant_o        (grant_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      icache_req_i = 1'b0; dcache_req_i = 1'b0; periph_req_i = 1'b0;
      dcache_we_i = 1'b0; periph_we_i = 1'b0;
      ack_i = 1'b0; data_i = '0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_cyc(output bit ok);
      int n = 0;
      while (!cyc_o && n < 20) begin
         tick();
         n++;
      end
      ok = cyc_o;
   endtask

   // Acts as the bus slave for one transaction; call when cyc_o has just risen.
   task automatic bus_txn(input int waits, input bit give_ack, input logic [31:0] rdv,
                          output obs_t o);
      o.g = grant_o; o.a = addr_o; o.w = we_o; o.d = data_o;
      o.stable = 1'b1;
      o.len = 0;
      while (cyc_o && o.len < 100) begin
         if (give_ack && o.len == waits) begin
            ack_i = 1'b1; data_i = rdv;
         end else begin
            ack_i = 1'b0; data_i = $urandom;
         end
         if ({grant_o, addr_o, we_o, data_o} !== {o.g, o.a, o.w, o.d} || stb_o !== 1'b1)
            o.stable = 1'b0;
         tick();
         o.len++;
      end
      ack_i = 1'b0;
      o.rsp = {periph_rsp_o, dcache_rsp_o, icache_rsp_o};
      o.rd  = rdata_o;
      o.er  = err_o;
   endtask

   // Reference round robin: first pending requester after the last owner.
   function automatic int rr_expect(input int last, input bit [2:0] p);
      for (int k = 1; k <= 3; k++) begin
         int idx = (last - 1 + k) % 3;
         if (p[idx]) return idx + 1;
      end
      return 0;
   endfunction

   task automatic test_reset();
      clear_inputs();
      icache_req_i = 1'b1;
      #3;
      n_total++;
      if ({cyc_o, stb_o, we_o, addr_o, data_o, rdata_o, err_o, icache_rsp_o, dcache_rsp_o,
           periph_rsp_o, grant_o} !== '0)
         $display("FAIL reset_outputs: got cyc=%b addr=%h grant=%0d, want all zero", cyc_o, addr_o, grant_o);
      else n_pass++;
      tick();
      tick();
      n_total++;
      if ({cyc_o, grant_o} !== 3'b000)
         $display("FAIL reset_hold: got cyc=%b grant=%0d, want 0/0", cyc_o, grant_o);
      else n_pass++;
      icache_req_i = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_icache_read();
      int lat;
      logic [31:0] a_cap = '1;
      logic w_cap = 1'b1;
      logic [1:0] g_cap = '0;
      apply_reset();
      icache_req_i = 1'b1;
      icache_addr_i = 32'h0000_0100;
      lat = 1;
      while (!icache_rsp_o && lat < 10) begin
         ack_i = cyc_o;
         data_i = cyc_o ? 32'h0000_0013 : 32'h0;
         if (cyc_o) begin a_cap = addr_o; w_cap = we_o; g_cap = grant_o; end
         tick();
         lat++;
      end
      ack_i = 1'b0;
      n_total++;
      if (lat !== 3) $display("FAIL icache_latency: got %0d cycles, want 3", lat);
      else n_pass++;
      n_total++;
      if ({g_cap, a_cap, w_cap} !== {2'd1, 32'h0000_0100, 1'b0})
         $display("FAIL icache_bus: got grant=%0d addr=%h we=%b, want 1/00000100/0", g_cap, a_cap, w_cap);
      else n_pass++;
      n_total++;
      if ({rdata_o, err_o, cyc_o, dcache_rsp_o, periph_rsp_o} !== {32'h13, 4'b0000})
         $display("FAIL icache_rsp: got rdata=%h err=%b cyc=%b, want 00000013/0/0", rdata_o, err_o, cyc_o);
      else n_pass++;
      icache_req_i = 1'b0;
      tick();
      n_total++;
      if ({icache_rsp_o, grant_o} !== 3'b000)
         $display("FAIL icache_pulse: got rsp=%b grant=%0d, want 0/0", icache_rsp_o, grant_o);
      else n_pass++;
      // ack with no transaction in flight must change nothing
      ack_i = 1'b1;
      data_i = 32'hDEAD_BEEF;
      tick(); tick(); tick();
      ack_i = 1'b0;
      n_total++;
      if ({rdata_o, cyc_o, icache_rsp_o, dcache_rsp_o, periph_rsp_o} !== {32'h13, 4'b0000})
         $display("FAIL idle_ack: got rdata=%h cyc=%b, want 00000013/0", rdata_o, cyc_o);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      obs_t o;
      bit ok;
      int prev_edge = 0;
      apply_reset();
      icache_req_i = 1'b1; icache_addr_i = 32'h0000_1000;
      dcache_req_i = 1'b1; dcache_addr_i = 32'h0000_2000; dcache_we_i = 1'b0;
      periph_req_i = 1'b1; periph_addr_i = 32'h8000_0000; periph_we_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wait_cyc(ok);
         bus_txn(0, 1'b1, $urandom, o);
         n_total++;
         if ({o.g, o.rsp, o.er, o.stable} !== {2'((k % 3) + 1), 3'(3'b001 << (k % 3)), 1'b0, 1'b1})
            $display("FAIL rr_order[%0d]: got grant=%0d rsp=%b err=%b, want grant=%0d", k, o.g, o.rsp, o.er, (k % 3) + 1);
         else n_pass++;
         if (k > 0) begin
            n_total++;
            if (edge_cnt - prev_edge !== 3)
               $display("FAIL rr_throughput[%0d]: got %0d cycles between rsp, want 3", k, edge_cnt - prev_edge);
            else n_pass++;
         end
         prev_edge = edge_cnt;
      end
      clear_inputs();
      tick(); tick();
   endtask

   task automatic test_dcache_write();
      obs_t o;
      bit ok;
      dcache_req_i = 1'b1; dcache_we_i = 1'b1;
      dcache_addr_i = 32'h0000_2000; dcache_wdata_i = 32'hCAFE_F00D;
      wait_cyc(ok);
      bus_txn(4, 1'b1, 32'h1234_5678, o);
      n_total++;
      if ({o.g, o.a, o.w, o.d, o.stable, o.len} !== {2'd2, 32'h0000_2000, 1'b1, 32'hCAFE_F00D, 1'b1, 32'd5})
         $display("FAIL dwrite_bus: got grant=%0d addr=%h we=%b data=%h stable=%b active=%0d, want 2/00002000/1/cafef00d/1/5",
                  o.g, o.a, o.w, o.d, o.stable, o.len);
      else n_pass++;
      n_total++;
      if ({o.rsp, o.er, o.rd} !== {3'b010, 1'b0, 32'h1234_5678})
         $display("FAIL dwrite_rsp: got rsp=%b err=%b rdata=%h, want 010/0/12345678", o.rsp, o.er, o.rd);
      else n_pass++;
      dcache_req_i = 1'b0;
      tick();
      n_total++;
      if (dcache_rsp_o !== 1'b0) $display("FAIL dwrite_pulse: got rsp=%b, want 0", dcache_rsp_o);
      else n_pass++;
   endtask

   task automatic test_timeout();
      obs_t o;
      bit ok;
      periph_req_i = 1'b1; periph_we_i = 1'b0; periph_addr_i = 32'h8000_0004;
      wait_cyc(ok);
      bus_txn(0, 1'b0, 32'h0, o);
      n_total++;
      if ({o.a, o.len, o.rsp, o.er, o.rd} !== {32'h8000_0004, 32'(TO + 1), 3'b100, 1'b1, 32'h0})
         $display("FAIL timeout: got addr=%h cycles=%0d rsp=%b err=%b rdata=%h, want 80000004/%0d/100/1/0",
                  o.a, o.len, o.rsp, o.er, o.rd, TO + 1);
      else n_pass++;
      periph_req_i = 1'b0;
      tick();
      periph_req_i = 1'b1;
      wait_cyc(ok);
      bus_txn(TO, 1'b1, 32'hA5A5_0001, o);
      n_total++;
      if ({o.len, o.rsp, o.er, o.rd} !== {32'(TO + 1), 3'b100, 1'b0, 32'hA5A5_0001})
         $display("FAIL ack_vs_timeout: got cycles=%0d rsp=%b err=%b rdata=%h, want %0d/100/0/a5a50001",
                  o.len, o.rsp, o.er, o.rd, TO + 1);
      else n_pass++;
      periph_req_i = 1'b0;
      tick(); tick();
   endtask

   task automatic test_flush();
      obs_t o;
      bit ok;
      apply_reset();
      icache_req_i = 1'b1; icache_addr_i = 32'h0000_0040;
      dcache_req_i = 1'b1; dcache_we_i = 1'b0; dcache_addr_i = 32'h0000_3000;
      wait_cyc(ok);
      icache_req_i = 1'b0;
      bus_txn(2, 1'b1, 32'h0BAD_F00D, o);
      n_total++;
      if ({o.g, o.len, o.rsp, o.er} !== {2'd1, 32'd3, 3'b001, 1'b0})
         $display("FAIL flush_complete: got grant=%0d cycles=%0d rsp=%b err=%b, want 1/3/001/0", o.g, o.len, o.rsp, o.er);
      else n_pass++;
      wait_cyc(ok);
      n_total++;
      if ({ok, grant_o, addr_o} !== {1'b1, 2'd2, 32'h0000_3000})
         $display("FAIL flush_next: got cyc=%b grant=%0d addr=%h, want 1/2/00003000", ok, grant_o, addr_o);
      else n_pass++;
      bus_txn(0, 1'b1, 32'h1, o);
      dcache_req_i = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_mid_active();
      bit ok;
      apply_reset();
      periph_req_i = 1'b1; periph_we_i = 1'b1;
      periph_addr_i = 32'h8000_0010; periph_wdata_i = 32'h5555_AAAA;
      wait_cyc(ok);
      tick();
      n_total++;
      if ({cyc_o, we_o, grant_o} !== {1'b1, 1'b1, 2'd3})
         $display("FAIL midreset_pre: got cyc=%b we=%b grant=%0d, want 1/1/3", cyc_o, we_o, grant_o);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({cyc_o, stb_o, grant_o, periph_rsp_o} !== 5'b0)
         $display("FAIL midreset_drop: got cyc=%b stb=%b grant=%0d rsp=%b, want 0/0/0/0", cyc_o, stb_o, grant_o, periph_rsp_o);
      else n_pass++;
      periph_req_i = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      n_total++;
      if ({cyc_o, periph_rsp_o} !== 2'b00)
         $display("FAIL midreset_norsp: got cyc=%b rsp=%b, want 0/0", cyc_o, periph_rsp_o);
      else n_pass++;
   endtask

   task automatic drive_reqs(input bit [2:0] p, input logic [31:0] a0, a1, a2, wd1, wd2,
                             input logic w1, w2);
      icache_req_i = p[0]; icache_addr_i = a0;
      dcache_req_i = p[1]; dcache_addr_i = a1; dcache_wdata_i = wd1; dcache_we_i = w1;
      periph_req_i = p[2]; periph_addr_i = a2; periph_wdata_i = wd2; periph_we_i = w2;
   endtask

   task automatic test_random();
      int last;
      int exp;
      bit [2:0] pend;
      logic [31:0] a[3];
      logic [31:0] wd[3];
      logic w[3];
      logic [31:0] rdv;
      obs_t o;
      bit ok;
      apply_reset();
      last = 3;
      for (int i = 0; i < 3; i++) begin
         a[i] = $urandom; wd[i] = $urandom;
         w[i] = (i != 0) && ($urandom_range(0, 1) == 1);
      end
      a[2][31] = 1'b1;
      pend = 3'($urandom_range(1, 7));
      drive_reqs(pend, a[0], a[1], a[2], wd[1], wd[2], w[1], w[2]);
      for (int t = 0; t < 40; t++) begin
         wait_cyc(ok);
         n_total++;
         if (!ok) $display("FAIL rand_grant_wait[%0d]: got no cyc within 20 cycles, want cyc", t);
         else n_pass++;
         exp = rr_expect(last, pend);
         rdv = $urandom;
         bus_txn($urandom_range(0, 3), 1'b1, rdv, o);
         n_total++;
         if ({o.g, o.a, o.w} !== {2'(exp), a[exp-1], w[exp-1]})
            $display("FAIL rand_bus[%0d]: got grant=%0d addr=%h we=%b, want %0d/%h/%b",
                     t, o.g, o.a, o.w, exp, a[exp-1], w[exp-1]);
         else n_pass++;
         if (w[exp-1]) begin
            n_total++;
            if (o.d !== wd[exp-1]) $display("FAIL rand_wdata[%0d]: got %h, want %h", t, o.d, wd[exp-1]);
            else n_pass++;
         end
         n_total++;
         if ({o.rsp, o.er, o.rd, o.stable} !== {3'(3'b001 << (exp - 1)), 1'b0, rdv, 1'b1})
            $display("FAIL rand_rsp[%0d]: got rsp=%b err=%b rdata=%h stable=%b, want rsp for %0d rdata=%h",
                     t, o.rsp, o.er, o.rd, o.stable, exp, rdv);
         else n_pass++;
         last = exp;
         pend[exp-1] = 1'b0;
         for (int j = 0; j < 3; j++) begin
            if (!pend[j] && $urandom_range(0, 1) == 1) begin
               pend[j] = 1'b1;
               a[j] = $urandom; wd[j] = $urandom;
               w[j] = (j != 0) && ($urandom_range(0, 1) == 1);
               if (j == 2) a[j][31] = 1'b1;
            end
         end
         if (pend == 3'b000) begin
            pend[0] = 1'b1;
            a[0] = $urandom;
         end
         drive_reqs(pend, a[0], a[1], a[2], wd[1], wd[2], w[1], w[2]);
      end
      clear_inputs();
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_icache_read();
      test_round_robin();
      test_dcache_write();
      test_timeout();
      test_flush();
      test_reset_mid_active();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Sequential arbiter that shares the single external Wishbone-style memory bus among three requesters: the I-cache refill port, the D-cache refill/write-back port and the uncached peripheral port (`addr[31]=1`). It replaces combinational muxing with a registered, round-robin, one-transaction-at-a-time controller that has a bus-timeout watchdog. It sits in the processor top level, between the caches/core and the bus pins.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `TIMEOUT_CYCLES`, 1024: cycles in ACTIVE without `ack_i` before the transaction is aborted. 0 disables the watchdog.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `icache_req_i`  in  1  I-cache read request. Level signal, held until `icache_rsp_o`.
- `icache_addr_i`  in  ADDR_WIDTH  I-cache address.
- `icache_rsp_o`  out  1  one-cycle completion pulse.
- `dcache_req_i`, `dcache_we_i`  in  1  D-cache request and write flag.
- `dcache_addr_i`, `dcache_wdata_i`  in  ADDR/DATA_WIDTH  D-cache address and write data.
- `dcache_rsp_o`  out  1  one-cycle completion pulse.
- `periph_req_i`, `periph_we_i`  in  1  uncached peripheral request and write flag.
- `periph_addr_i`, `periph_wdata_i`  in  ADDR/DATA_WIDTH  peripheral address and write data.
- `periph_rsp_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  DATA_WIDTH  registered read data, shared by all requesters, valid while any `*_rsp_o` is high.
- `err_o`  out  1  high with `*_rsp_o` when the transaction timed out.
- `cyc_o`, `stb_o`, `we_o`  out  1  bus strobes. `stb_o` equals `cyc_o`.
- `addr_o`, `data_o`  out  ADDR/DATA_WIDTH  bus address and write data.
- `ack_i`  in  1  bus acknowledge.
- `data_i`  in  DATA_WIDTH  bus read data.
- `grant_o`  out  2  current owner: 0 none, 1 icache, 2 dcache, 3 periph.

## Operation
- FSM states: IDLE, ACTIVE, RESP.
- **IDLE:** if any request is high, pick the winner by round-robin, starting after the last granted requester. Latch its addr/wdata/we into the bus output registers, set `grant_o`, clear the timeout counter, and go to ACTIVE.
- **ACTIVE:**
  - `cyc_o`/`stb_o` are high; bus outputs are stable.
  - On `ack_i`: latch `data_i` into `rdata_o` (also on writes), `err_o`=0, go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES` first: `rdata_o`=0, `err_o`=1, go to RESP.
  - `ack_i` and timeout in the same cycle: `ack_i` wins.
- **RESP:**
  - `cyc_o`=0; pulse the granted requester's `*_rsp_o` for exactly one cycle.
  - Update the last-grant pointer, clear `grant_o`, go to IDLE.
- Requester contract:
  - Keep request and payload stable until `*_rsp_o`, then drop the request in the same cycle.
  - A request dropped while granted (e.g. I-cache flush) does not abort the bus cycle. The transaction completes and `rsp` still pulses; the requester ignores it.
- Address routing between caches and peripheral is done by the requesters. The arbiter does not decode addresses.
- Round-robin pointer reset value: last=periph, so icache has priority first.

## Timing
- Reset (asynchronous, immediate): state=IDLE and all outputs 0, i.e. `cyc_o`, `stb_o`, `we_o`, `addr_o`, `data_o`, `rdata_o`, `err_o`, `*_rsp_o`, `grant_o`. Pointer=periph. Reset mid-ACTIVE drops `cyc_o` without a response.
- Request high in IDLE at edge t gives `cyc_o` high from t+1.
- `ack_i` sampled high at edge a gives `rsp` and `rdata_o` at a+1 and `cyc_o` low at a+1.
- Next grant earliest at a+2 (sample), with `cyc_o` at a+3.
- Zero-wait-state bus (ack in the first ACTIVE cycle): 3 cycles from request sample to `rsp`; back-to-back throughput is one transaction per 3 cycles.
- Timeout: `rsp`+`err_o` appear `TIMEOUT_CYCLES`+1 cycles after `cyc_o` rises.
- `ack_i` outside ACTIVE is ignored.

## Structure
- Package `bus_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ACTIVE, RESP};
  - grant constants `GNT_NONE`/`GNT_ICACHE`/`GNT_DCACHE`/`GNT_PERIPH`;
  - timeout counter width function `$clog2(TIMEOUT_CYCLES+1)`.
- Sub-module `rr_pick3`: combinational three-way round-robin selector, inputs req[2:0] and last grant, output winner. Everything else lives in `memory_bus_arbiter`.

## Test plan
- Reset during ACTIVE with periph write pending -> `cyc_o`=0 immediately, no `periph_rsp_o`, `grant_o`=0.
- Single icache read addr 0x0000_0100, `ack_i` one cycle after `cyc_o`, `data_i`=0x0000_0013 -> `addr_o`=0x100, `we_o`=0, `icache_rsp_o` one pulse, `rdata_o`=0x13, 3 cycles request→rsp.
- All three requests held continuously -> grant order icache, dcache, periph, icache…; no requester granted twice in a row while others wait.
- dcache write 0x0000_2000 data 0xCAFE_F00D with 4 wait states -> `we_o`=1, `data_o` stable for 5 ACTIVE cycles, `dcache_rsp_o` one cycle after ack, `err_o`=0.
- Peripheral read 0x8000_0004, `ack_i` never asserted, `TIMEOUT_CYCLES`=16 -> `periph_rsp_o`+`err_o`=1 and `rdata_o`=0 exactly 17 cycles after `cyc_o` rises; ack and timeout coinciding -> `err_o`=0.
- icache drops request mid-ACTIVE (flush) -> bus cycle completes on `ack_i`, `icache_rsp_o` still pulses, pending dcache request granted next.
